uart_codec_sequencer: RTL and testbench

UART_CODEC_SEQUENCER -- requirements
Module: uart_codec_sequencer

---
 rtl/uart_codec_sequencer_pkg.sv | 36 +++
 rtl/uart_codec_sequencer_rx_timeout_counter.sv | 47 ++++
 rtl/uart_codec_sequencer.sv | 101 ++++++++++
 tb/tb_uart_codec_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_codec_sequencer_pkg.sv
// Shared types and constants for the UART codec sequencer and its helpers.
package uart_package;

  localparam int OVERSAMPLE_DEFAULT        = 16;
  localparam int TIMEOUT_BIT_TIMES_DEFAULT = 40;

  // Sub-bit index at which a receiver samples the middle of a bit.
  function automatic int rx_sample_point(input int oversample);
    return oversample / 2 - 1;
  endfunction

  localparam int RX_SAMPLE_POINT = OVERSAMPLE_DEFAULT / 2 - 1;

  // Frame progress. START..STOP are in-frame states; IDLE and TIMEOUT wait for a start.
  typedef enum logic [3:0] {
    IDLE,
    START,
    SEL_0,
    SEL_1,
    SEL_2,
    SEL_3,
    SEL_4,
    SEL_5,
    SEL_6,
    DATA_END,
    PARITY,
    STOP,
    TIMEOUT
  } codec_state_t;

  typedef struct packed {
    codec_state_t state;
    logic         start;
  } u_codec_t;

endpackage

// File: rtl/uart_codec_sequencer_rx_timeout_counter.sv
// Counts bit times spent waiting for the next character; saturates at LIMIT.
module uart_rx_timeout_counter
  import uart_package::*;
#(
  parameter int LIMIT = TIMEOUT_BIT_TIMES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          expired_q, expired_d;

  // Next count saturates at LIMIT; expiry follows one clock after the count gets there.
  always_comb begin
    cnt_d     = cnt_q;
    expired_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (!clear && (cnt_q == LIMIT_C)) begin
      expired_d = 1'b1;
    end
  end

  // Count and expiry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/uart_codec_sequencer.sv
// Bit-timing sequencer for a UART codec: advances the externally computed
// frame state at bit boundaries, produces bit strobes and the RX idle timeout.
module uart_codec_sequencer
  import uart_package::*;
#(
  parameter int OVERSAMPLE        = OVERSAMPLE_DEFAULT,
  parameter int TIMEOUT_BIT_TIMES = TIMEOUT_BIT_TIMES_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         baud_tick,
  input  logic         receiver_mode,
  input  logic         serial_in,
  input  logic         tx_request,
  input  codec_state_t next_state,
  output u_codec_t     codec,
  output logic         bit_strobe,
  output logic         timeout_signal
);

  localparam int SW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [SW-1:0] SUB_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SUB_SAMPLE = SW'(rx_sample_point(OVERSAMPLE));

  codec_state_t  state_q, state_d;
  logic [SW-1:0] sub_cnt_q, sub_cnt_d;
  logic          strobe_q, strobe_d;

  logic bit_end;
  logic sample_tick;
  logic waiting;
  logic start_window;
  logic start_flag;

  assign bit_end      = baud_tick && (sub_cnt_q == SUB_LAST);
  assign sample_tick  = baud_tick && (sub_cnt_q == SUB_SAMPLE);
  assign waiting      = (state_q == IDLE) || (state_q == TIMEOUT);
  // STOP also listens so a new frame can follow the stop bit with no gap.
  assign start_window = waiting || (state_q == STOP);
  assign start_flag   = start_window && (receiver_mode ? !serial_in : tx_request);

  assign codec = '{state: state_q, start: start_flag};

  // Next state, sub-bit counter and strobe decision.
  always_comb begin
    state_d   = state_q;
    sub_cnt_d = sub_cnt_q;
    strobe_d  = 1'b0;

    if (baud_tick) begin
      sub_cnt_d = (sub_cnt_q == SUB_LAST) ? '0 : sub_cnt_q + 1'b1;
    end

    if (waiting) begin
      // Waiting states follow next_state every tick; a new frame restarts bit timing.
      if (baud_tick) begin
        state_d = next_state;
        if (next_state == START) begin
          sub_cnt_d = '0;
        end
      end
    end else if (receiver_mode && (state_q == START) && sample_tick && serial_in) begin
      // Line back high mid start bit: it was a glitch, not a character.
      state_d = IDLE;
    end else if (bit_end) begin
      state_d = next_state;
    end

    if (receiver_mode) begin
      strobe_d = sample_tick && !waiting && (state_q != START);
    end else begin
      strobe_d = baud_tick && !waiting && (sub_cnt_q == '0);
    end
  end

  // State, sub-bit counter and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sub_cnt_q <= '0;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sub_cnt_q <= sub_cnt_d;
      strobe_q  <= strobe_d;
    end
  end

  assign bit_strobe = strobe_q;

  uart_rx_timeout_counter #(
    .LIMIT(TIMEOUT_BIT_TIMES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (bit_end),
    .clear  (state_q != TIMEOUT),
    .expired(timeout_signal)
  );

endmodule

// File: tb/tb_uart_codec_sequencer.sv
// Scoreboard bench for uart_codec_sequencer with a random RX/TX line model.
module tb_uart_codec_sequencer;
  import uart_package::*;

  localparam int EV_STROBE = 1;
  localparam int EV_TO     = 2;

  typedef struct packed {
    int kind;
    int tick;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         baud_tick;
  logic         receiver_mode;
  logic         serial_in;
  logic         tx_request;
  codec_state_t ns;
  u_codec_t     codec;
  logic         bit_strobe;
  logic         timeout_signal;

  int  total = 0;
  int  bad   = 0;
  int  tick_no = 0;
  int  cfg_nd = 8;
  bit  cfg_par = 1'b0;
  bit  data_ready = 1'b0;
  ev_t sb[$];

  always #5 clk = ~clk;

  uart_codec_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .baud_tick     (baud_tick),
    .receiver_mode (receiver_mode),
    .serial_in     (serial_in),
    .tx_request    (tx_request),
    .next_state    (ns),
    .codec         (codec),
    .bit_strobe    (bit_strobe),
    .timeout_signal(timeout_signal)
  );

  function automatic codec_state_t sel_state(input int i);
    case (i)
      0: return SEL_0;
      1: return SEL_1;
      2: return SEL_2;
      3: return SEL_3;
      4: return SEL_4;
      5: return SEL_5;
      default: return SEL_6;
    endcase
  endfunction

  function automatic int sel_index(input codec_state_t s);
    case (s)
      SEL_0: return 0;
      SEL_1: return 1;
      SEL_2: return 2;
      SEL_3: return 3;
      SEL_4: return 4;
      SEL_5: return 5;
      default: return 6;
    endcase
  endfunction

  // Frame state expected during bit j of a character (0 = start bit).
  function automatic codec_state_t bit_state(input int j, input int nd, input bit par);
    if (j == 0) return START;
    if (j < nd) return sel_state(j - 1);
    if (j == nd) return DATA_END;
    if (par && (j == nd + 1)) return PARITY;
    return STOP;
  endfunction

  // Stand-in for the external codec next-state function.
  always_comb begin
    ns = codec.state;
    case (codec.state)
      IDLE:     ns = codec.start ? START : IDLE;
      START:    ns = SEL_0;
      SEL_0, SEL_1, SEL_2, SEL_3, SEL_4, SEL_5, SEL_6:
        ns = (sel_index(codec.state) >= cfg_nd - 2) ? DATA_END
                                                     : sel_state(sel_index(codec.state) + 1);
      DATA_END: ns = cfg_par ? PARITY : STOP;
      PARITY:   ns = STOP;
      STOP:     ns = codec.start ? START
                               : ((receiver_mode && data_ready) ? TIMEOUT : IDLE);
      TIMEOUT:  ns = codec.start ? START : (timeout_signal ? IDLE : TIMEOUT);
      default:  ns = IDLE;
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d (tick %0d)", name, act, exp, tick_no);
    end
  endtask

  task automatic check_event(input int kind, input string name);
    ev_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s actual=event at tick %0d expected=no event", name, tick_no);
    end else begin
      e = sb.pop_front();
      chk({name, "_kind"}, kind, e.kind);
      chk({name, "_tick"}, tick_no, e.tick);
    end
  endtask

  // Monitor: every strobe and every timeout rise must match the next queued event.
  initial begin
    bit prev_to;
    prev_to = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bit_strobe === 1'b1) check_event(EV_STROBE, "strobe");
      if ((timeout_signal === 1'b1) && !prev_to) check_event(EV_TO, "timeout_rise");
      prev_to = (timeout_signal === 1'b1);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog actual=still running expected=finished");
    $fatal(1, "watchdog expired");
  end

  // One baud_tick after 1..3 quiet clocks; called and returns at a falling edge.
  task automatic tick();
    int gap;
    gap = $urandom_range(1, 3);
    baud_tick = 1'b0;
    repeat (gap) @(negedge clk);
    baud_tick = 1'b1;
    tick_no++;
    @(negedge clk);
    baud_tick = 1'b0;
  endtask

  task automatic rx_frame(input logic [7:0] data, input int nd, input bit par);
    int nb;
    int t0;
    logic [11:0] bits;
    bit p;
    nb = nd + int'(par) + 2;
    cfg_nd = nd;
    cfg_par = par;
    p = 1'b0;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < nd; i++) begin
      bits[1 + i] = data[i];
      p ^= data[i];
    end
    if (par) bits[nd + 1] = p;
    bits[nb - 1] = 1'b1;
    t0 = tick_no + 1;
    for (int i = 0; i < nb - 1; i++) sb.push_back('{kind: EV_STROBE, tick: t0 + 24 + 16 * i});
    for (int j = 0; j < nb; j++) begin
      serial_in = bits[j];
      repeat (16) tick();
    end
  endtask

  task automatic tx_burst(input int nd, input bit par, input int nf);
    int nb;
    int t0;
    nb = nd + int'(par) + 2;
    cfg_nd = nd;
    cfg_par = par;
    receiver_mode = 1'b0;
    t0 = tick_no + 1;
    for (int i = 0; i < nf * nb; i++) sb.push_back('{kind: EV_STROBE, tick: t0 + 1 + 16 * i});
    tx_request = 1'b1;
    for (int k = 0; k < nf * nb * 16; k++) begin
      tick();
      chk("tx_state", int'(codec.state), int'(bit_state((k / 16) % nb, nd, par)));
      if (k == (nf - 1) * nb * 16 + 20) tx_request = 1'b0;
    end
    tick();
    chk("tx_end_idle", int'(codec.state), int'(IDLE));
    receiver_mode = 1'b1;
  endtask

  initial begin
    int t0;
    int tend;
    int n;
    rst_n = 1'b0;
    baud_tick = 1'b0;
    receiver_mode = 1'b1;
    serial_in = 1'b1;
    tx_request = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", int'(codec.state), int'(IDLE));
    chk("rst_strobe", int'(bit_strobe), 0);
    chk("rst_timeout", int'(timeout_signal), 0);
    chk("rst_start", int'(codec.start), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("hold_no_tick", int'(codec.state), int'(IDLE));
    repeat (5) tick();

    // RX 0x55 8N1: nine strobes, first 24 ticks after the falling edge.
    rx_frame(8'h55, 8, 1'b0);
    repeat (20) tick();
    chk("rx55_idle", int'(codec.state), int'(IDLE));

    // Random RX frames, random gaps including back-to-back.
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(0, 12);
      repeat (n) tick();
      data_ready = (f == 5) ? 1'b0 : 1'($urandom_range(0, 1));
      rx_frame(8'($urandom), $urandom_range(0, 1) ? 8 : 7, 1'($urandom_range(0, 1)));
    end
    repeat (20) tick();
    chk("rand_rx_idle", int'(codec.state), int'(IDLE));

    // 8-tick low glitch: false start.
    cfg_nd = 8;
    cfg_par = 1'b0;
    serial_in = 1'b0;
    repeat (8) tick();
    chk("glitch_start", int'(codec.state), int'(START));
    serial_in = 1'b1;
    tick();
    chk("glitch_idle", int'(codec.state), int'(IDLE));
    repeat (30) tick();
    chk("glitch_stays_idle", int'(codec.state), int'(IDLE));

    // Timeout expiry after 40 bit times.
    data_ready = 1'b1;
    rx_frame(8'($urandom), 8, 1'b0);
    tend = tick_no + 1;
    sb.push_back('{kind: EV_TO, tick: tend + 640});
    repeat (641) tick();
    chk("to_still_waiting", int'(codec.state), int'(TIMEOUT));
    tick();
    chk("to_goes_idle", int'(codec.state), int'(IDLE));
    chk("to_signal_held", int'(timeout_signal), 1);
    @(negedge clk);
    chk("to_signal_clear", int'(timeout_signal), 0);
    data_ready = 1'b0;
    repeat (5) tick();

    // Start at bit time 39 of the timeout window wins over the timeout.
    data_ready = 1'b1;
    rx_frame(8'($urandom), 8, 1'b0);
    repeat (629) tick();
    chk("to39_state", int'(codec.state), int'(TIMEOUT));
    chk("to39_signal", int'(timeout_signal), 0);
    data_ready = 1'b0;
    rx_frame(8'($urandom), 8, 1'b0);
    repeat (10) tick();
    chk("to39_idle", int'(codec.state), int'(IDLE));

    // TX bursts with tx_request held.
    tx_burst(7, 1'b1, 3);
    repeat (5) tick();
    tx_burst(8, 1'b0, 2);
    repeat (5) tick();

    // Asynchronous reset in the middle of SEL_3.
    cfg_nd = 8;
    cfg_par = 1'b0;
    serial_in = 1'b0;
    t0 = tick_no + 1;
    for (int i = 0; i < 3; i++) sb.push_back('{kind: EV_STROBE, tick: t0 + 24 + 16 * i});
    n = 0;
    while ((codec.state != SEL_3) && (n < 200)) begin
      tick();
      n++;
    end
    chk("reach_sel3", int'(codec.state), int'(SEL_3));
    chk("reach_sel3_tick", tick_no, t0 + 64);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", int'(codec.state), int'(IDLE));
    chk("arst_strobe", int'(bit_strobe), 0);
    chk("arst_timeout", int'(timeout_signal), 0);
    @(negedge clk);
    serial_in = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_release_idle", int'(codec.state), int'(IDLE));
    repeat (40) tick();
    chk("arst_after_idle", int'(codec.state), int'(IDLE));

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
